// File: rtl/apb_slv_pkg.sv
// rtl/apb_slv_pkg.sv - shared types, widths and address check for the APB memory completer
//
// Purpose: common definitions imported by apb_slave_mem_bfm and apb_slv_proto_chk.
//   state_t  : completer FSM states (IDLE, ACCESS)
//   APB_DW   : data width, APB_AW : address width, CNT_W : scoring counter width
//   addr_err : 1 when a byte address is misaligned or outside [base, base+depth*4)

package apb_slv_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // The upper limit is formed in APB_AW+1 bits so a window ending exactly at
  // the top of the address space does not wrap to zero.
  function automatic logic addr_err(input logic [APB_AW-1:0] addr,
                                    input logic [APB_AW-1:0] base,
                                    input logic [APB_AW-1:0] depth);
    logic [APB_AW:0] lim;
    lim = {1'b0, base} + ({1'b0, depth} << 2);
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= lim);
  endfunction

endpackage

// File: rtl/apb_slv_proto_chk.sv
// rtl/apb_slv_proto_chk.sv - sticky APB protocol-violation monitor for the memory completer
//
// Purpose: raises proto_err (sticky until rst) when the requester breaks APB3
// sequencing while this completer is selected.
// Ports:
//   clk, rst        : bus clock, asynchronous active-high reset
//   psel, penable   : live APB control
//   pwrite, paddr,
//   pwdata          : live APB transfer attributes
//   addr_q, write_q,
//   wdata_q         : values latched by the completer in the setup phase
//   state           : completer FSM state
//   proto_err       : sticky violation flag

module apb_slv_proto_chk
  import apb_slv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [APB_DW-1:0] pwdata,
  input  logic [APB_AW-1:0] addr_q,
  input  logic              write_q,
  input  logic [APB_DW-1:0] wdata_q,
  input  state_t            state,
  output logic              proto_err
);

  logic v_enable_idle;
  logic v_changed;
  logic v_abort;
  logic v_enable_drop;
  logic viol;

  assign v_enable_idle = (state == IDLE) && penable;
  assign v_changed     = (state == ACCESS) && psel &&
                         ((paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q));
  assign v_abort       = (state == ACCESS) && !psel;
  assign v_enable_drop = (state == ACCESS) && psel && !penable;
  assign viol          = v_enable_idle || v_changed || v_abort || v_enable_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (viol) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: rtl/apb_slave_mem_bfm.sv
// rtl/apb_slave_mem_bfm.sv - APB3 completer with word memory, wait states, PSLVERR and scoring counters
//
// Purpose: single-slot APB3 target backed by a DEPTH x 32-bit memory at BASE_ADDR.
// Optional protocol checker enabled by defining APB_SLV_PROTO_CHECK_EN.
// Ports:
//   PCLK, PRESET        : bus clock, asynchronous active-high reset
//   PSEL, PENABLE       : slot select, access phase
//   PWRITE, PADDR,
//   PWDATA              : transfer direction, byte address, write data
//   PRDATA, PREADY,
//   PSLVERR             : read data, completion, error response
//   cfg_wait            : wait states per transfer, sampled at setup
//   wr_cnt, rd_cnt,
//   err_cnt             : completed good writes, good reads, error responses
//   proto_err           : sticky protocol-violation flag (0 without the checker)

module apb_slave_mem_bfm
  import apb_slv_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR = 32'h0000_0000,
  parameter int                DEPTH     = 256,
  parameter int                WAITW     = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic [WAITW-1:0]  cfg_wait,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              proto_err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t            state;
  state_t            state_n;
  logic              ready_q;
  logic              err_q;
  logic              write_q;
  logic [WAITW-1:0]  wcnt;
  logic [IDXW-1:0]   idx_q;
  logic [APB_DW-1:0] wdata_q;
  logic [APB_DW-1:0] rdata_q;
  logic [CNT_W-1:0]  wr_q;
  logic [CNT_W-1:0]  rd_q;
  logic [CNT_W-1:0]  errc_q;

  logic [APB_DW-1:0] mem [DEPTH];

  logic              setup;
  logic              access;
  logic              complete;
  logic              setup_err;
  logic [IDXW-1:0]   setup_idx;

  assign setup     = (state == IDLE) && PSEL && !PENABLE;
  assign access    = (state == ACCESS) && PSEL && PENABLE;
  assign complete  = access && ready_q;
  assign setup_err = addr_err(PADDR, BASE_ADDR, APB_AW'(DEPTH));
  // Out-of-range addresses alias into the array here, but err_q blocks both
  // the read data and the commit, so the alias is never observable.
  assign setup_idx = IDXW'((PADDR - BASE_ADDR) >> 2);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (setup) begin
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL || complete) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      wcnt    <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      errc_q  <= '0;
    end else if (setup) begin
      write_q <= PWRITE;
      wdata_q <= PWDATA;
      idx_q   <= setup_idx;
      wcnt    <= cfg_wait;
      err_q   <= setup_err;
      // Read data is captured at setup; a write committed on the previous
      // completion edge is already in the array by now.
      rdata_q <= setup_err ? '0 : mem[setup_idx];
      ready_q <= (cfg_wait == '0);
    end else if (state == ACCESS) begin
      if (!PSEL) begin
        ready_q <= 1'b0;
      end else if (PENABLE) begin
        if (!ready_q) begin
          wcnt    <= wcnt - 1'b1;
          ready_q <= (wcnt == WAITW'(1));
        end else begin
          ready_q <= 1'b0;
          if (err_q) begin
            errc_q <= errc_q + 1'b1;
          end else if (write_q) begin
            wr_q <= wr_q + 1'b1;
          end else begin
            rd_q <= rd_q + 1'b1;
          end
        end
      end
    end
  end

  // Memory has no reset; a reset mid-transfer forces IDLE so complete is low.
  always_ff @(posedge PCLK) begin
    if (complete && write_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign PREADY  = ready_q;
  assign PSLVERR = ready_q & err_q;
  assign PRDATA  = (ready_q && !write_q && !err_q) ? rdata_q : '0;
  assign wr_cnt  = wr_q;
  assign rd_cnt  = rd_q;
  assign err_cnt = errc_q;

`ifdef APB_SLV_PROTO_CHECK_EN
  logic [APB_AW-1:0] addr_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q <= '0;
    end else if (setup) begin
      addr_q <= PADDR;
    end
  end

  apb_slv_proto_chk u_proto_chk (
    .clk       (PCLK),
    .rst       (PRESET),
    .psel      (PSEL),
    .penable   (PENABLE),
    .pwrite    (PWRITE),
    .paddr     (PADDR),
    .pwdata    (PWDATA),
    .addr_q    (addr_q),
    .write_q   (write_q),
    .wdata_q   (wdata_q),
    .state     (state),
    .proto_err (proto_err)
  );
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_mem_bfm.sv
// tb/tb_apb_slave_mem_bfm.sv - self-checking bench for apb_slave_mem_bfm

module tb_apb_slave_mem_bfm;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;
  localparam int          WAITW = 4;
`ifdef APB_SLV_PROTO_CHECK_EN
  localparam logic        PROTO = 1'b1;
`else
  localparam logic        PROTO = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [3:0]  cfg_wait;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [15:0] err_cnt;
  logic        proto_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wt;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];

  apb_slave_mem_bfm #(
    .BASE_ADDR (BASE),
    .DEPTH     (DEPTH),
    .WAITW     (WAITW)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .cfg_wait  (cfg_wait),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt),
    .err_cnt   (err_cnt),
    .proto_err (proto_err)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge PCLK);
    #1;
  endtask

  task automatic bus_idle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    cycle();
  endtask

  // One complete transfer; returns PRDATA/PSLVERR seen with PREADY and the
  // access cycle (1-based) in which PREADY first rose, 0 on timeout.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wt, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = wr;
    PADDR    = addr;
    PWDATA   = wdata;
    cfg_wait = wt;
    cycle();
    PENABLE  = 1'b1;
    cfg_wait = ~wt;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    n     = 0;
    while (lat == 0 && n < 40) begin
      n++;
      if (PREADY) begin
        lat   = n;
        rdata = PRDATA;
        err   = PSLVERR;
      end else begin
        cycle();
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL xfer_timeout addr=%h actual=no_PREADY required=PREADY", addr);
    end
    cycle();
  endtask

  task automatic chk_cnt(input string tag, input int w, input int r, input int e);
    chk({tag, "_wr_cnt"},  32'(wr_cnt),  32'(w));
    chk({tag, "_rd_cnt"},  32'(rd_cnt),  32'(r));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    vecs[0]  = '{1'b1, BASE + 32'h010, 32'hDEAD_BEEF, 4'd0,  32'h0,         1'b0};
    vecs[1]  = '{1'b0, BASE + 32'h010, 32'h0,         4'd0,  32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, BASE + 32'h000, 32'h1234_5678, 4'd1,  32'h0,         1'b0};
    vecs[3]  = '{1'b0, BASE + 32'h000, 32'h0,         4'd3,  32'h1234_5678, 1'b0};
    vecs[4]  = '{1'b1, BASE + 32'h400, 32'hFFFF_FFFF, 4'd0,  32'h0,         1'b1};
    vecs[5]  = '{1'b1, BASE + 32'h002, 32'h0BAD_F00D, 4'd0,  32'h0,         1'b1};
    vecs[6]  = '{1'b0, BASE + 32'h002, 32'h0,         4'd0,  32'h0,         1'b1};
    vecs[7]  = '{1'b0, BASE - 32'h004, 32'h0,         4'd2,  32'h0,         1'b1};
    vecs[8]  = '{1'b1, BASE + 32'h3FC, 32'hAAAA_5555, 4'd2,  32'h0,         1'b0};
    vecs[9]  = '{1'b0, BASE + 32'h3FC, 32'h0,         4'd15, 32'hAAAA_5555, 1'b0};
    vecs[10] = '{1'b1, BASE + 32'h020, 32'h0000_0001, 4'd0,  32'h0,         1'b0};
    vecs[11] = '{1'b1, BASE + 32'h020, 32'h0000_0002, 4'd0,  32'h0,         1'b0};
    vecs[12] = '{1'b0, BASE + 32'h020, 32'h0,         4'd0,  32'h0000_0002, 1'b0};
    vecs[13] = '{1'b0, BASE + 32'h010, 32'h0,         4'd1,  32'hDEAD_BEEF, 1'b0};
    vecs[14] = '{1'b0, BASE + 32'h000, 32'h0,         4'd0,  32'h1234_5678, 1'b0};
    vecs[15] = '{1'b1, BASE + 32'h030, 32'h1111_1111, 4'd0,  32'h0,         1'b0};
    vecs[16] = '{1'b1, BASE + 32'h040, 32'h2222_2222, 4'd1,  32'h0,         1'b0};
    vecs[17] = '{1'b1, BASE + 32'h060, 32'h4444_4444, 4'd0,  32'h0,         1'b0};

    PRESET   = 1'b1;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    PADDR    = '0;
    PWDATA   = '0;
    cfg_wait = '0;
    cycle();
    cycle();
    chk("rst_PREADY",    32'(PREADY),    32'h0);
    chk("rst_PSLVERR",   32'(PSLVERR),   32'h0);
    chk("rst_PRDATA",    PRDATA,         32'h0);
    chk("rst_proto_err", 32'(proto_err), 32'h0);
    chk_cnt("rst", 0, 0, 0);
    PRESET = 1'b0;
    cycle();

    // Table: consecutive transfers with no idle cycle between them.
    for (int i = 0; i < 18; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wt, rd, er, lat);
      chk($sformatf("v%0d_PRDATA", i),  rd,       vecs[i].exp_rdata);
      chk($sformatf("v%0d_PSLVERR", i), 32'(er),  32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(int'(vecs[i].wt) + 1));
      if (i == 1) begin
        chk_cnt("after_wr_rd", 1, 1, 0);
      end
    end
    bus_idle();
    chk_cnt("table", 8, 6, 4);

    // Address changed mid-access: latched address must be used.
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = 1'b1;
    PADDR    = BASE + 32'h050;
    PWDATA   = 32'h3333_3333;
    cfg_wait = 4'd1;
    cycle();
    PENABLE = 1'b1;
    PADDR   = BASE + 32'h060;
    n = 0;
    while (!PREADY && n < 20) begin
      n++;
      cycle();
    end
    chk("addr_chg_latency", 32'(n + 1), 32'd2);
    cycle();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    cycle();
    chk("addr_chg_proto_err", 32'(proto_err), 32'(PROTO));
    xfer(1'b0, BASE + 32'h050, 32'h0, 4'd0, rd, er, lat);
    chk("addr_chg_latched_word", rd, 32'h3333_3333);
    xfer(1'b0, BASE + 32'h060, 32'h0, 4'd0, rd, er, lat);
    chk("addr_chg_other_word", rd, 32'h4444_4444);
    bus_idle();
    chk("proto_err_sticky", 32'(proto_err), 32'(PROTO));

    // Abort: PSEL drops during the wait, nothing commits or counts.
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = 1'b1;
    PADDR    = BASE + 32'h040;
    PWDATA   = 32'hBADB_AD00;
    cfg_wait = 4'd2;
    cycle();
    PENABLE = 1'b1;
    cycle();
    chk("abort_wait_PREADY", 32'(PREADY), 32'h0);
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    cycle();
    chk("abort_PREADY", 32'(PREADY), 32'h0);
    chk_cnt("abort", 9, 8, 4);
    xfer(1'b0, BASE + 32'h040, 32'h0, 4'd0, rd, er, lat);
    chk("abort_no_commit", rd, 32'h2222_2222);
    chk("abort_next_latency", 32'(lat), 32'd1);
    bus_idle();
    chk_cnt("after_abort", 9, 9, 4);

    // Reset during the wait of a write: dropped, counters cleared.
    PSEL     = 1'b1;
    PENABLE  = 1'b0;
    PWRITE   = 1'b1;
    PADDR    = BASE + 32'h030;
    PWDATA   = 32'hCAFE_F00D;
    cfg_wait = 4'd5;
    cycle();
    PENABLE = 1'b1;
    cycle();
    cycle();
    PRESET = 1'b1;
    #1;
    chk("midrst_PREADY",    32'(PREADY),    32'h0);
    chk("midrst_PRDATA",    PRDATA,         32'h0);
    chk("midrst_proto_err", 32'(proto_err), 32'h0);
    chk_cnt("midrst", 0, 0, 0);
    @(posedge PCLK);
    #1;
    PRESET  = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    cycle();
    xfer(1'b0, BASE + 32'h030, 32'h0, 4'd0, rd, er, lat);
    chk("postrst_no_commit", rd, 32'h1111_1111);
    chk("postrst_latency",   32'(lat), 32'd1);
    chk("postrst_PSLVERR",   32'(er),  32'h0);
    bus_idle();
    chk_cnt("postrst", 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
